// File: rtl/muldiv_pkg.sv
// muldiv_pkg: operand width, RV32M funct3 encodings and FSM state encoding
// shared by the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 5;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: combinational conditional two's-complement negation.
// Used for operand magnitudes and for the final sign correction.
module muldiv_sign_fix #(
    parameter int unsigned W = 64
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg,
    output logic [W-1:0] o_val
);

    assign o_val = i_neg ? ((~i_val) + W'(1)) : i_val;

endmodule

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative radix-2 RV32M multiply/divide on one shared 64-bit shift/accumulate path.
// Optional MULDIV_EARLY_TERM_EN: multiplies leave CALC once the remaining multiplier bits are zero.
module muldiv_iter
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    state_t              r_state, w_state_next;
    logic [2:0]          r_op;
    logic                r_neg;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_opb;
    logic [XLEN-1:0]     r_result;

    logic                w_a_signed, w_b_signed, w_sign_a, w_sign_b, w_neg_start;
    logic                w_div_zero, w_ovf, w_special;
    logic [XLEN-1:0]     w_abs_a, w_abs_b, w_special_res, w_final;
    logic                w_is_mul, w_mul_last, w_last;
    logic [XLEN:0]       w_sum, w_top, w_diff;
    logic [2*XLEN-1:0]   w_mul_next, w_div_next, w_acc_next, w_prod, w_fix_in, w_fix_out;

    always_comb begin
        w_a_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH) || (funct3 == F3_MULHSU)
                     || (funct3 == F3_DIV) || (funct3 == F3_REM);
        w_b_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH)
                     || (funct3 == F3_DIV) || (funct3 == F3_REM);
        w_sign_a   = w_a_signed & src_a[XLEN-1];
        w_sign_b   = w_b_signed & src_b[XLEN-1];
        // Remainder follows the dividend; product and quotient follow the sign xor.
        w_neg_start = (funct3[2] && funct3[1]) ? w_sign_a : (w_sign_a ^ w_sign_b);
        w_div_zero  = funct3[2] && (src_b == '0);
        w_ovf       = funct3[2] && !funct3[0] && (src_a == 32'h8000_0000) && (src_b == '1);
        w_special   = w_div_zero || w_ovf;
        if (w_div_zero) begin
            w_special_res = funct3[1] ? src_a : '1;
        end else begin
            w_special_res = funct3[1] ? '0 : 32'h8000_0000;
        end
    end

    muldiv_sign_fix #(.W(XLEN)) u_abs_a (.i_val(src_a), .i_neg(w_sign_a), .o_val(w_abs_a));
    muldiv_sign_fix #(.W(XLEN)) u_abs_b (.i_val(src_b), .i_neg(w_sign_b), .o_val(w_abs_b));

    assign w_is_mul = !r_op[2];

    // Multiply shifts right (multiplier in the low half); divide shifts left (dividend low).
    always_comb begin
        w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
        w_mul_next = {w_sum, r_acc[XLEN-1:1]};
        w_top      = r_acc[2*XLEN-1:XLEN-1];
        w_diff     = w_top - {1'b0, r_opb};
        w_div_next = {(w_diff[XLEN] ? w_top[XLEN-1:0] : w_diff[XLEN-1:0]),
                      r_acc[XLEN-2:0], ~w_diff[XLEN]};
        w_acc_next = w_is_mul ? w_mul_next : w_div_next;
    end

`ifdef MULDIV_EARLY_TERM_EN
    logic [XLEN-1:0]  r_mrem;
    logic [CNT_W-1:0] w_shamt;

    assign w_mul_last = (r_mrem[XLEN-1:1] == '0);
    assign w_shamt    = CNT_W'(XLEN - 1) - r_cnt;
    // Unprocessed multiplier bits are zero, so the partial product only needs aligning.
    assign w_prod     = w_mul_next >> w_shamt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mrem <= '0;
        end else if (r_state == IDLE && start) begin
            r_mrem <= w_abs_b;
        end else if (r_state == CALC) begin
            r_mrem <= r_mrem >> 1;
        end
    end
`else
    assign w_mul_last = 1'b0;
    assign w_prod     = w_mul_next;
`endif

    assign w_last = (r_cnt == CNT_W'(XLEN - 1)) || (w_is_mul && w_mul_last);

    always_comb begin
        if (w_is_mul) begin
            w_fix_in = w_prod;
        end else if (r_op[1]) begin
            w_fix_in = {{XLEN{1'b0}}, w_div_next[2*XLEN-1:XLEN]};
        end else begin
            w_fix_in = {{XLEN{1'b0}}, w_div_next[XLEN-1:0]};
        end
    end

    muldiv_sign_fix #(.W(2*XLEN)) u_fix (.i_val(w_fix_in), .i_neg(r_neg), .o_val(w_fix_out));

    assign w_final = ((r_op == F3_MUL) || r_op[2]) ? w_fix_out[XLEN-1:0]
                                                   : w_fix_out[2*XLEN-1:XLEN];

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_state_next = w_special ? DONE : CALC;
            CALC:    if (w_last) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_result <= '0;
        end else if (r_state == IDLE && start) begin
            r_op  <= funct3;
            r_neg <= w_neg_start;
            r_cnt <= '0;
            r_acc <= {{XLEN{1'b0}}, (funct3[2] ? w_abs_a : w_abs_b)};
            r_opb <= funct3[2] ? w_abs_b : w_abs_a;
            if (w_special) begin
                r_result <= w_special_res;
            end
        end else if (r_state == CALC) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_result <= w_final;
            end
        end
    end

    assign busy   = (r_state == CALC);
    assign done   = (r_state == DONE);
    assign result = r_result;

endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: random and directed RV32M operations checked every cycle against
// an arithmetic reference model of result, latency, busy and done.
module tb_muldiv_iter;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] src_a, src_b;
    logic        busy, done;
    logic [31:0] result;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state: accept edge, done edge, expected result, previous result.
    logic        m_active = 1'b0;
    int          m_acc    = 0;
    int          m_done   = 0;
    logic [31:0] m_res    = '0;
    logic [31:0] m_prev   = '0;
    logic        e_busy, e_done;

    muldiv_iter u_dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .src_a  (src_a),
        .src_b  (src_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic logic is_special(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
        if (f[2] && b == 32'h0) return 1'b1;
        if ((f == 3'b100 || f == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_res(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] sa, sb, za, zb, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        za = {32'h0, a};
        zb = {32'h0, b};
        case (f)
            3'b000: begin p = sa * sb; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * zb; return p[63:32]; end
            3'b011: begin p = za * zb; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Edges from the start-drive edge to the edge after which done is high.
    function automatic int model_lat(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
        if (is_special(f, a, b)) return 1;
`ifdef MULDIV_EARLY_TERM_EN
        if (!f[2]) begin
            logic [31:0] m;
            int n;
            m = ((f == 3'b000 || f == 3'b001) && b[31]) ? -b : b;
            n = 1;
            for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
            return 1 + n;
        end
`endif
        return 33;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        e_busy = m_active && (cyc >= m_acc) && (cyc < m_done);
        e_done = m_active && (cyc == m_done);
        check("busy", 32'(busy), 32'(e_busy));
        check("done", 32'(done), 32'(e_done));
        if (!m_active || cyc < m_acc) check("result_hold", result, m_prev);
        else if (cyc >= m_done) check("result", result, m_res);
    end

    // mode 0: plain; 1: extra start pulse mid-CALC; 2: extra start pulse during DONE.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int mode, input logic use_lit, input logic [31:0] lit);
        int lat;
        int used;
        @(posedge clk);
        #1;
        if (m_active) m_prev = m_res;
        lat      = model_lat(f, a, b);
        m_res    = model_res(f, a, b);
        m_acc    = cyc + 1;
        m_done   = cyc + lat;
        m_active = 1'b1;
        start  = 1'b1;
        funct3 = f;
        src_a  = a;
        src_b  = b;
        @(posedge clk);
        #1;
        used   = 1;
        start  = 1'b0;
        funct3 = 3'($urandom);
        src_a  = $urandom;
        src_b  = $urandom;
        if (mode == 1 && lat > 8) begin
            repeat (4) @(posedge clk);
            #1;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            src_a = $urandom;
            used += 5;
        end
        while (used < lat) begin
            @(posedge clk);
            #1;
            used++;
        end
        if (use_lit) check("literal", result, lit);
        if (mode == 2) begin
            start  = 1'b1;
            funct3 = 3'($urandom);
            src_a  = $urandom;
            src_b  = $urandom;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
    endtask

    initial begin
        start  = 1'b0;
        funct3 = 3'b000;
        src_a  = '0;
        src_b  = '0;
        reset  = 1'b0;
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check("model_mul",   model_res(3'b000, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        check("model_mulhu", model_res(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
        check("model_div",   model_res(3'b100, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        check("model_rem",   model_res(3'b110, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);

        run_op(3'b000, 32'd7,          32'hFFFF_FFFD, 0, 1'b1, 32'hFFFF_FFEB);
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 0, 1'b1, 32'h4000_0000);
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1, 32'hFFFF_FFFE);
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1, 32'hFFFF_FFFF);
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2,          0, 1'b1, 32'hFFFF_FFFD);
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2,          0, 1'b1, 32'hFFFF_FFFF);
        run_op(3'b101, 32'd100,        32'd7,          0, 1'b1, 32'd14);
        run_op(3'b111, 32'd100,        32'd7,          0, 1'b1, 32'd2);
        run_op(3'b101, 32'd5,          32'd0,          0, 1'b1, 32'hFFFF_FFFF);
        run_op(3'b110, 32'd5,          32'd0,          0, 1'b1, 32'd5);
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1, 32'h8000_0000);
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1, 32'h0);

        // Abort at CALC counter 10.
        @(posedge clk);
        #1;
        m_prev   = m_res;
        m_res    = model_res(3'b000, 32'd1234, 32'd5678);
        m_acc    = cyc + 1;
        m_done   = cyc + model_lat(3'b000, 32'd1234, 32'd5678);
        m_active = 1'b1;
        start    = 1'b1;
        funct3   = 3'b000;
        src_a    = 32'd1234;
        src_b    = 32'd5678;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("reset_busy",   32'(busy), 32'h0);
        check("reset_done",   32'(done), 32'h0);
        check("reset_result", result,    32'h0);
        m_active = 1'b0;
        m_prev   = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (40) @(posedge clk);

        run_op(3'b000, 32'h0001_2345, 32'h0000_0100, 1, 1'b1, 32'h0123_4500);
        run_op(3'b101, 32'd1000,       32'd10,        2, 1'b1, 32'd100);
        run_op(3'b000, 32'd3,          32'd5,         0, 1'b1, 32'd15);

        for (int i = 0; i < 60; i++) begin
            run_op(3'($urandom), rand_operand(), rand_operand(), int'($urandom_range(0, 2)),
                   1'b0, 32'h0);
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
